wb_scheduler: RTL and testbench
===============================

# wb_scheduler

Writeback scheduler and reservation controller for the general register file. It shares the single register-file write port among `N_REQ` functional units using round-robin arbitration. It keeps a per-register busy scoreboard that mirrors the write-reservation state of the register cells, and drives each cell's reservation and writeback strobes. It sits between decode/issue, the execution units, and the array of register cells.

## Interface
Parameters:
- `W_OPR`, 32, operand/register data width
- `W_RADDR`, 5, register address width
- `N_REG`, 32, number of registers (= 2**`W_RADDR`)
- `N_REQ`, 4, number of writeback requesters

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `issue_valid_i`  in  1  decode wants to reserve `issue_dst_i`
- `issue_dst_i`  in  `W_RADDR`  destination register to reserve
- `issue_ready_o`  out  1  reservation accepted this cycle
- `src_a_i`, `src_b_i`  in  `W_RADDR` each  source registers to check
- `hazard_o`  out  1  a source register is reserved (RAW hazard)
- `req_valid_i`  in  `N_REQ`  per-unit writeback request
- `req_addr_i`  in  `N_REQ*W_RADDR`  packed destination addresses; unit k at bits [k*W_RADDR +: W_RADDR]
- `req_data_i`  in  `N_REQ*W_OPR`  packed result data
- `req_ready_o`  out  `N_REQ`  one-hot grant; the request is consumed this cycle
- `w_reserve_o`  out  `N_REG`  one-hot reservation strobe to the cells
- `wb_o`  out  `N_REG`  one-hot writeback strobe to the cells
- `wb_data_o`  out  `W_OPR`  data bus shared by all cells
- `busy_o`  out  `N_REG`  scoreboard; bit r set while register r is reserved

## Operation
- Issue handshake:
  - `issue_ready_o = issue_valid_i & (~busy[dst] | wb_o[dst])`. A writeback in flight to dst frees it for back-to-back reuse.
  - `w_reserve_o[dst] = issue_valid_i & issue_ready_o`. This is combinational, a one-cycle pulse.
- Hazard:
  - `hazard_o = busy[src_a_i] | busy[src_b_i]`. Combinational; no bypass.
- Writeback arbitration:
  - A requester holds `valid`, `addr` and `data` stable until its `req_ready_o` is high (valid/ready).
  - Round-robin: the search starts at `last_grant+1` mod `N_REQ`. The first valid requester wins.
  - At most one grant per cycle.
  - `last_grant` updates only on a cycle with a grant.
- Output stage:
  - The winner's addr/data are registered.
  - Next cycle, `wb_o[addr]` = 1 for exactly one cycle and `wb_data_o` = data.
  - `wb_data_o` holds its last value when idle.
  - Throughput is one writeback per cycle.
- Scoreboard, per register r, at each edge:
  - If `w_reserve_o[r]`: busy ← 1.
  - Else if `wb_o[r]`: busy ← 0.
  - Reserve wins over writeback, matching the cell.
- A writeback to a non-busy register is still performed; busy stays 0.
- Reset:
  - busy all 0, `wb_o` 0, `wb_data_o` 0, output-stage valid 0.
  - `last_grant` = `N_REQ-1`, so unit 0 has first priority.
  - `issue_ready_o`, `req_ready_o` and `w_reserve_o` are forced 0 while `reset` is high.
  - A granted-but-unwritten result is dropped on reset.

## Timing
- Request valid at cycle t with no contention: `req_ready_o` is high at t, and `wb_o`/`wb_data_o` are valid at t+1.
- The cell latches the data and clears its reservation at the t+1→t+2 edge. `busy_o` clears at the same edge.
- Issue at cycle t: `w_reserve_o` pulses at t, and `busy_o` = 1 from t+1.
- `hazard_o` and `issue_ready_o` reflect scoreboard state as of the start of the cycle.
- Contention among k requesters: each waits at most `N_REQ-1` grant cycles.
- Simultaneous issue to register r and `wb_o[r]`: issue is accepted, and busy[r] remains 1 afterward.

## Structure
- Shared params include: `W_OPR`, `W_RADDR`, `N_REG`.
- Sub-module `rr_arbiter`, parameterised by `N_REQ`:
  - Inputs: `req` vector, `advance`.
  - Outputs: one-hot `grant`.
  - Owns the `last_grant` register.
- The remaining logic (issue check, scoreboard, output register, decoders) stays in `wb_scheduler`.

## Test plan
- Reset release, issue r5 at t0: `w_reserve_o[5]` pulses at t0, and `busy_o[5]` = 1 at t1. Then `hazard_o` = 1 with `src_a_i` = 5.
- Unit 2 writes r5 with `32'hDEADBEEF` at t2: `req_ready_o` = `4'b0100` at t2, `wb_o[5]` = 1 with `wb_data_o` = `32'hDEADBEEF` at t3, and `busy_o[5]` = 0 at t4.
- All four units valid and held for 4 cycles from reset: grant order is 0,1,2,3, and 4 distinct `wb_o` pulses occur on consecutive cycles.
- Issue to r7 while `wb_o[7]` = 1: `issue_ready_o` = 1, and `busy_o[7]` stays 1.
- Issue to busy r9 with no writeback pending: `issue_ready_o` = 0, and no `w_reserve_o` pulse.
- Reset asserted the cycle after a grant: no `wb_o` pulse follows, and `busy_o`, `wb_data_o` are 0 after the edge.

Source files
------------

// File: rtl/wb_scheduler_pkg.sv
// Shared parameters for the writeback scheduler slice.
// Defaults describe the 32 x 32-bit register file with four writeback units.
// No logic lives here.
package wb_scheduler_pkg;
  localparam int W_OPR   = 32;
  localparam int W_RADDR = 5;
  localparam int N_REG   = 32;
  localparam int N_REQ   = 4;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
// Combinational grant, zero latency; last_grant register updates on granted cycles.
// Requesters not granted simply keep their request asserted.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] grant_idx;
  logic          found;

  // Search from last_grant+1 (wrapping) and grant the first active requester.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req[(int'(last_grant) + i) % N_REQ]) begin
        grant[(int'(last_grant) + i) % N_REQ] = 1'b1;
        grant_idx = IW'((int'(last_grant) + i) % N_REQ);
        found     = 1'b1;
      end
    end
  end

  // Remember the winner; reset points at the top unit so unit 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IW'(N_REQ - 1);
    end else if (advance && found) begin
      last_grant <= grant_idx;
    end
  end
endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: shares the regfile write port and tracks per-register reservations.
// Grant at cycle t, wb_o/wb_data_o at t+1; issue/hazard are combinational off the scoreboard.
// Issue stalls via issue_ready_o while dst is busy; losing units hold until req_ready_o.
module wb_scheduler #(
  parameter int W_OPR   = wb_scheduler_pkg::W_OPR,
  parameter int W_RADDR = wb_scheduler_pkg::W_RADDR,
  parameter int N_REG   = wb_scheduler_pkg::N_REG,
  parameter int N_REQ   = wb_scheduler_pkg::N_REQ
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid_i,
  input  logic [W_RADDR-1:0]       issue_dst_i,
  output logic                     issue_ready_o,
  input  logic [W_RADDR-1:0]       src_a_i,
  input  logic [W_RADDR-1:0]       src_b_i,
  output logic                     hazard_o,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*W_RADDR-1:0] req_addr_i,
  input  logic [N_REQ*W_OPR-1:0]   req_data_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [N_REG-1:0]         w_reserve_o,
  output logic [N_REG-1:0]         wb_o,
  output logic [W_OPR-1:0]         wb_data_o,
  output logic [N_REG-1:0]         busy_o
);
  import wb_scheduler_pkg::*;

  logic [N_REG-1:0]   busy;
  logic [N_REQ-1:0]   grant;
  logic [W_RADDR-1:0] sel_addr;
  logic [W_OPR-1:0]   sel_data;
  logic               stage_vld;
  logic [W_RADDR-1:0] stage_addr;

  assign busy_o = busy;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid_i),
    .advance (!reset),
    .grant   (grant)
  );

  // Issue accept, reservation strobe and RAW hazard; a writeback landing on dst frees it.
  always_comb begin
    issue_ready_o = !reset && issue_valid_i && (!busy[issue_dst_i] || wb_o[issue_dst_i]);
    w_reserve_o   = '0;
    if (issue_ready_o) w_reserve_o[issue_dst_i] = 1'b1;
    hazard_o      = busy[src_a_i] || busy[src_b_i];
  end

  // Mux out the granted unit's address and data.
  always_comb begin
    req_ready_o = reset ? '0 : grant;
    sel_addr    = '0;
    sel_data    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = req_addr_i[k*W_RADDR +: W_RADDR];
        sel_data = req_data_i[k*W_OPR +: W_OPR];
      end
    end
  end

  // Output stage: capture the winner; data bus keeps its last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_vld  <= 1'b0;
      stage_addr <= '0;
      wb_data_o  <= '0;
    end else begin
      stage_vld <= |req_ready_o;
      if (|req_ready_o) begin
        stage_addr <= sel_addr;
        wb_data_o  <= sel_data;
      end
    end
  end

  // Decode the staged address into the one-cycle writeback strobe; reset drops it.
  always_comb begin
    wb_o = '0;
    if (stage_vld && !reset) wb_o[stage_addr] = 1'b1;
  end

  // Scoreboard: reservation wins over a same-cycle writeback, as in the cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~wb_o) | w_reserve_o;
    end
  end
endmodule

// File: tb/tb_wb_scheduler.sv
// Directed bench for wb_scheduler: issue/hazard, writeback timing, round-robin order,
// back-to-back reuse, blocked issue and reset dropping an in-flight result.
module tb_wb_scheduler;
  localparam int W_OPR = 32, W_RADDR = 5, N_REG = 32, N_REQ = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     issue_valid;
  logic [W_RADDR-1:0]       issue_dst;
  logic                     issue_ready;
  logic [W_RADDR-1:0]       src_a, src_b;
  logic                     hazard;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*W_RADDR-1:0] req_addr;
  logic [N_REQ*W_OPR-1:0]   req_data;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REG-1:0]         w_reserve, wb, busy;
  logic [W_OPR-1:0]         wb_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_scheduler dut (
    .clk(clk), .reset(reset),
    .issue_valid_i(issue_valid), .issue_dst_i(issue_dst), .issue_ready_o(issue_ready),
    .src_a_i(src_a), .src_b_i(src_b), .hazard_o(hazard),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data),
    .req_ready_o(req_ready), .w_reserve_o(w_reserve), .wb_o(wb),
    .wb_data_o(wb_data), .busy_o(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [W_RADDR-1:0] a, input logic [W_OPR-1:0] d);
    req_valid[k] = 1'b1;
    req_addr[k*W_RADDR +: W_RADDR] = a;
    req_data[k*W_OPR +: W_OPR] = d;
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_dst = '0; src_a = '0; src_b = '0;
    req_valid = '0; req_addr = '0; req_data = '0;
    tick; tick;

    // Reset: handshakes forced low, state cleared
    issue_valid = 1'b1; issue_dst = 5'd3; req_valid = 4'hF; #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'd0);
    chk("rst_w_reserve",   64'(w_reserve),   64'd0);
    chk("rst_req_ready",   64'(req_ready),   64'd0);
    chk("rst_busy",        64'(busy),        64'd0);
    chk("rst_wb",          64'(wb),          64'd0);
    chk("rst_wb_data",     64'(wb_data),     64'd0);
    issue_valid = 1'b0; req_valid = '0;
    tick;
    reset = 1'b0;

    // t0: reserve r5
    issue_valid = 1'b1; issue_dst = 5'd5; #1;
    chk("t0_issue_ready", 64'(issue_ready), 64'd1);
    chk("t0_w_reserve",   64'(w_reserve),   64'h20);
    tick;
    // t1: busy set, hazard on src_a
    issue_valid = 1'b0; src_a = 5'd5; #1;
    chk("t1_busy",   64'(busy),   64'h20);
    chk("t1_hazard", 64'(hazard), 64'd1);
    src_a = 5'd0; src_b = 5'd4; #1;
    chk("t1_no_hazard", 64'(hazard), 64'd0);
    src_b = 5'd5; #1;
    chk("t1_hazard_b", 64'(hazard), 64'd1);
    src_b = 5'd0;
    tick;
    // t2: unit 2 writes r5
    set_req(2, 5'd5, 32'hDEADBEEF); #1;
    chk("t2_req_ready", 64'(req_ready), 64'b0100);
    chk("t2_wb",        64'(wb),        64'd0);
    tick;
    // t3: writeback strobe, busy still set
    req_valid = '0; #1;
    chk("t3_wb",      64'(wb),      64'h20);
    chk("t3_wb_data", 64'(wb_data), 64'hDEADBEEF);
    chk("t3_busy",    64'(busy),    64'h20);
    tick;
    // t4: busy cleared, data bus holds
    chk("t4_busy",    64'(busy),    64'd0);
    chk("t4_wb",      64'(wb),      64'd0);
    chk("t4_wb_data", 64'(wb_data), 64'hDEADBEEF);

    // Round robin from reset: all four valid, each drops after its grant
    reset = 1'b1; tick; reset = 1'b0;
    for (int k = 0; k < N_REQ; k++) set_req(k, 5'(10 + k), 32'hA0 + 32'(k));
    for (int i = 0; i < N_REQ; i++) begin
      #1;
      chk($sformatf("rr_grant%0d", i), 64'(req_ready), 64'(1) << i);
      chk($sformatf("rr_wb%0d", i), 64'(wb), (i == 0) ? 64'd0 : (64'(1) << (10 + i - 1)));
      tick;
      req_valid[i] = 1'b0;
    end
    #1;
    chk("rr_wb_last",   64'(wb),      64'(1) << 13);
    chk("rr_data_last", 64'(wb_data), 64'hA3);
    chk("rr_busy_idle", 64'(busy),    64'd0);
    tick;

    // last_grant=3: wrap to unit 0, then search skips past unit 0 to unit 2
    set_req(0, 5'd1, 32'h1); set_req(2, 5'd2, 32'h2); #1;
    chk("rr_wrap0", 64'(req_ready), 64'b0001);
    tick;
    req_valid[0] = 1'b0; set_req(0, 5'd3, 32'h3); #1;
    chk("rr_skip_to2", 64'(req_ready), 64'b0100);
    tick;
    req_valid[2] = 1'b0; #1;
    chk("rr_back_to0", 64'(req_ready), 64'b0001);
    tick;
    req_valid = '0;
    tick;

    // Reserve r7, write it back, re-issue r7 during the writeback
    issue_valid = 1'b1; issue_dst = 5'd7;
    tick;
    issue_valid = 1'b0; set_req(1, 5'd7, 32'h77); #1;
    chk("r7_grant", 64'(req_ready), 64'b0010);
    tick;
    req_valid = '0; issue_valid = 1'b1; issue_dst = 5'd7; #1;
    chk("r7_wb",          64'(wb),          64'h80);
    chk("r7_issue_ready", 64'(issue_ready), 64'd1);
    chk("r7_w_reserve",   64'(w_reserve),   64'h80);
    tick;
    issue_valid = 1'b0; #1;
    chk("r7_busy_kept", 64'(busy), 64'h80);

    // Reserve r9, then a second issue to r9 is blocked
    issue_valid = 1'b1; issue_dst = 5'd9;
    tick;
    #1;
    chk("r9_blocked",    64'(issue_ready), 64'd0);
    chk("r9_no_reserve", 64'(w_reserve),   64'd0);
    tick;
    issue_valid = 1'b0; #1;
    chk("r9_busy", 64'(busy), 64'h280);

    // Grant, then reset the next cycle: result dropped
    set_req(3, 5'd9, 32'h12345678); #1;
    chk("rst_drop_grant", 64'(req_ready), 64'b1000);
    tick;
    req_valid = '0; reset = 1'b1; #1;
    chk("rst_drop_wb_during", 64'(wb), 64'd0);
    tick;
    chk("rst_drop_busy", 64'(busy),    64'd0);
    chk("rst_drop_data", 64'(wb_data), 64'd0);
    reset = 1'b0;
    tick;
    chk("rst_drop_wb_after", 64'(wb), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
